// File: rtl/nes_pkg.sv
// Shared NES host-bus definitions: opcodes, host write payload and read FSM states.
package nes_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 8;

  localparam logic [OP_W-1:0] RESET_CPU   = OP_W'(0);
  localparam logic [OP_W-1:0] START_CPU   = OP_W'(1);
  localparam logic [OP_W-1:0] WRITE       = OP_W'(2);
  localparam logic [OP_W-1:0] SET_RD_ADDR = OP_W'(3);

  // Host writedata word: opcode in the upper byte, argument byte below.
  typedef struct packed {
    logic [OP_W-1:0] opcode;
    logic [7:0]      arg;
  } host_wdata_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ISSUE,
    RD_WAIT,
    RD_DONE
  } rd_state_e;

endpackage

// File: rtl/nes_mem_reader_if.sv
// Host slave bus shared by the NES top and the memory reader.
interface nes_mem_reader_if;
  import nes_pkg::*;

  logic              chipselect;
  logic              read;
  logic              write;
  host_wdata_t       writedata;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] readdata;
  logic              waitrequest;

  modport master (
    output chipselect, read, write, writedata, address,
    input  readdata, waitrequest
  );

  modport slave (
    input  chipselect, read, write, writedata, address,
    output readdata, waitrequest
  );

endinterface

// File: rtl/nes_rd_buffer.sv
// One-entry prefetch holding register (data + valid) for the memory reader.
module nes_rd_buffer
  import nes_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // Clear wins over load so a pointer reload always invalidates the entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/nes_mem_reader.sv
// Host read responder for NES memory: SET_RD_ADDR loads a pointer, each host read
// returns one byte and post-increments it. Define NES_RD_PREFETCH_EN for a 1-entry prefetch.
module nes_mem_reader
  import nes_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  nes_mem_reader_if.slave   host,
  input  logic              mem_grant,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_out,
  output logic [ADDR_W-1:0] rd_ptr
);

  rd_state_e         r_state;
  logic              r_mem_rd;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] r_rd_ptr;

  logic w_set_ptr;
  logic w_rd_req;
  logic w_start;
  logic w_unused;

  assign w_set_ptr = host.chipselect & host.write & (host.writedata.opcode == SET_RD_ADDR);
  assign w_rd_req  = host.chipselect & host.read;
  assign w_unused  = ^host.writedata.arg;

`ifdef NES_RD_PREFETCH_EN
  logic              w_buf_valid;
  logic [DATA_W-1:0] w_buf_data;
  logic              w_buf_load;
  logic              w_hit;

  // Fill whenever the buffer is empty; a host read only consumes it.
  assign w_hit      = w_rd_req & (r_state == RD_IDLE) & w_buf_valid;
  assign w_start    = (r_state == RD_IDLE) & mem_grant & ~w_buf_valid;
  assign w_buf_load = (r_state == RD_WAIT) & ~w_set_ptr;

  nes_rd_buffer u_rd_buffer (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_set_ptr | w_hit),
    .i_load  (w_buf_load),
    .i_data  (mem_out),
    .o_valid (w_buf_valid),
    .o_data  (w_buf_data)
  );

  assign host.readdata    = w_buf_data;
  assign host.waitrequest = w_rd_req & ~w_hit;
`else
  logic [DATA_W-1:0] r_readdata;

  assign w_start          = (r_state == RD_IDLE) & w_rd_req & mem_grant;
  assign host.readdata    = r_readdata;
  assign host.waitrequest = w_rd_req & (r_state != RD_DONE);
`endif

  // Read FSM; a pointer reload aborts any in-flight access back to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RD_IDLE;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_rd_ptr   <= '0;
`ifndef NES_RD_PREFETCH_EN
      r_readdata <= '0;
`endif
    end else if (w_set_ptr) begin
      r_rd_ptr <= host.address;
      r_state  <= RD_IDLE;
      r_mem_rd <= 1'b0;
    end else begin
      case (r_state)
        RD_IDLE: begin
          if (w_start) begin
            r_mem_addr <= r_rd_ptr;
            r_mem_rd   <= 1'b1;
            r_state    <= RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          r_mem_rd <= 1'b0;
          r_state  <= RD_WAIT;
        end
        RD_WAIT: begin
`ifdef NES_RD_PREFETCH_EN
          r_state <= RD_IDLE;
`else
          r_readdata <= mem_out;
          r_state    <= RD_DONE;
`endif
        end
        RD_DONE: begin
          r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
          r_state  <= RD_IDLE;
        end
        default: r_state <= RD_IDLE;
      endcase
`ifdef NES_RD_PREFETCH_EN
      if (w_hit) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
`endif
    end
  end

  assign mem_rd   = r_mem_rd;
  assign mem_addr = r_mem_addr;
  assign rd_ptr   = r_rd_ptr;

endmodule

// File: tb/tb_nes_mem_reader.sv
// Directed bench for nes_mem_reader with a synchronous 64 KiB memory model.
module tb_nes_mem_reader;
  import nes_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_grant;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_out;
  logic [15:0] rd_ptr;
  logic [7:0]  mem [0:65535];

  int checks   = 0;
  int failures = 0;

  nes_mem_reader_if bus();

  nes_mem_reader dut (
    .clk       (clk),
    .reset     (reset),
    .host      (bus),
    .mem_grant (mem_grant),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_out   (mem_out),
    .rd_ptr    (rd_ptr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_out <= mem[mem_addr];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ptr(input logic [15:0] a);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.writedata  = {SET_RD_ADDR, 8'h00};
    bus.address    = a;
    step();
    bus.write   = 1'b0;
    bus.address = 16'h0000;
  endtask

  // Holds read until waitrequest drops; waits = -1 if it never does.
  task automatic do_read(output logic [7:0] data, output int waits);
    waits = 0;
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    #1;
    while (bus.waitrequest === 1'b1 && waits < 40) begin
      waits++;
      step();
      #1;
    end
    if (bus.waitrequest !== 1'b0) waits = -1;
    data = bus.readdata;
    step();
    bus.read = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_grant = 1'b1;
    bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.writedata = '0; bus.address = '0;
    step(); step();
    checks++; if (rd_ptr !== 16'h0000) begin failures++; $display("FAIL reset_rd_ptr got %h want 0000", rd_ptr); end
    checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL reset_mem_rd got %b want 0", mem_rd); end
    checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL reset_mem_addr got %h want 0000", mem_addr); end
    checks++; if (bus.readdata !== 8'h00) begin failures++; $display("FAIL reset_readdata got %h want 00", bus.readdata); end
    checks++; if (bus.waitrequest !== 1'b0) begin failures++; $display("FAIL reset_waitreq got %b want 0", bus.waitrequest); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    set_ptr(16'h0010);
    checks++; if (rd_ptr !== 16'h0010) begin failures++; $display("FAIL basic_load got %h want 0010", rd_ptr); end
    bus.writedata = {WRITE, 8'hFF}; bus.address = 16'h1234; bus.write = 1'b1;
    step();
    bus.write = 1'b0;
    #1;
    checks++; if (rd_ptr !== 16'h0010) begin failures++; $display("FAIL basic_other_op got %h want 0010", rd_ptr); end
    bus.read = 1'b1;
    #1;
    checks++; if (bus.waitrequest !== 1'b1) begin failures++; $display("FAIL basic_wr_t0 got %b want 1", bus.waitrequest); end
    step(); #1;
    checks++; if (bus.waitrequest !== 1'b1) begin failures++; $display("FAIL basic_wr_t1 got %b want 1", bus.waitrequest); end
    checks++; if (mem_rd !== 1'b1) begin failures++; $display("FAIL basic_mem_rd_t1 got %b want 1", mem_rd); end
    checks++; if (mem_addr !== 16'h0010) begin failures++; $display("FAIL basic_mem_addr got %h want 0010", mem_addr); end
    step(); #1;
    checks++; if (bus.waitrequest !== 1'b1) begin failures++; $display("FAIL basic_wr_t2 got %b want 1", bus.waitrequest); end
    checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL basic_mem_rd_t2 got %b want 0", mem_rd); end
    step(); #1;
    checks++; if (bus.waitrequest !== 1'b0) begin failures++; $display("FAIL basic_wr_t3 got %b want 0", bus.waitrequest); end
    checks++; if (bus.readdata !== 8'hA5) begin failures++; $display("FAIL basic_data got %h want a5", bus.readdata); end
    step();
    bus.read = 1'b0;
    #1;
    checks++; if (rd_ptr !== 16'h0011) begin failures++; $display("FAIL basic_inc got %h want 0011", rd_ptr); end
  endtask

  task automatic test_back_to_back_wrap();
    logic [7:0] d;
    int w;
    set_ptr(16'hFFFF);
    do_read(d, w);
    checks++; if (d !== 8'h3C) begin failures++; $display("FAIL wrap_data0 got %h want 3c", d); end
    checks++; if (w !== 3) begin failures++; $display("FAIL wrap_waits0 got %0d want 3", w); end
    checks++; if (rd_ptr !== 16'h0000) begin failures++; $display("FAIL wrap_ptr0 got %h want 0000", rd_ptr); end
    do_read(d, w);
    checks++; if (d !== 8'h7E) begin failures++; $display("FAIL wrap_data1 got %h want 7e", d); end
    checks++; if (w !== 3) begin failures++; $display("FAIL wrap_waits1 got %0d want 3", w); end
    checks++; if (rd_ptr !== 16'h0001) begin failures++; $display("FAIL wrap_ptr1 got %h want 0001", rd_ptr); end
  endtask

  task automatic test_no_grant();
    int bad_wr = 0;
    int saw_rd = 0;
    int w = 0;
    set_ptr(16'h0020);
    mem_grant = 1'b0;
    bus.read  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.waitrequest !== 1'b1) bad_wr++;
      if (mem_rd !== 1'b0) saw_rd++;
      step();
    end
    checks++; if (bad_wr !== 0) begin failures++; $display("FAIL nogrant_wr low_cycles=%0d want 0", bad_wr); end
    checks++; if (saw_rd !== 0) begin failures++; $display("FAIL nogrant_mem_rd pulses=%0d want 0", saw_rd); end
    mem_grant = 1'b1;
    #1;
    while (bus.waitrequest === 1'b1 && w < 40) begin
      w++;
      step();
      #1;
    end
    checks++; if (w !== 3) begin failures++; $display("FAIL nogrant_waits got %0d want 3", w); end
    checks++; if (bus.readdata !== 8'h11) begin failures++; $display("FAIL nogrant_data got %h want 11", bus.readdata); end
    step();
    bus.read = 1'b0;
    #1;
    checks++; if (rd_ptr !== 16'h0021) begin failures++; $display("FAIL nogrant_ptr got %h want 0021", rd_ptr); end
  endtask

  task automatic test_abort();
    int w = 0;
    set_ptr(16'h0100);
    bus.read = 1'b1;
    step();
    step();
    bus.writedata = {SET_RD_ADDR, 8'h00}; bus.address = 16'h0200; bus.write = 1'b1;
    step();
    bus.write = 1'b0;
    #1;
    checks++; if (rd_ptr !== 16'h0200) begin failures++; $display("FAIL abort_load got %h want 0200", rd_ptr); end
    while (bus.waitrequest === 1'b1 && w < 40) begin
      w++;
      step();
      #1;
    end
    checks++; if (w !== 3) begin failures++; $display("FAIL abort_waits got %0d want 3", w); end
    checks++; if (bus.readdata !== 8'h44) begin failures++; $display("FAIL abort_data got %h want 44", bus.readdata); end
    step();
    bus.read = 1'b0;
    #1;
    checks++; if (rd_ptr !== 16'h0201) begin failures++; $display("FAIL abort_ptr got %h want 0201", rd_ptr); end
  endtask

  task automatic test_reset_in_wait();
    logic [7:0] d;
    int w;
    set_ptr(16'h0300);
    bus.read = 1'b1;
    step();
    step();
    reset = 1'b1;
    bus.read = 1'b0;
    step();
    #1;
    checks++; if (rd_ptr !== 16'h0000) begin failures++; $display("FAIL rstwait_ptr got %h want 0000", rd_ptr); end
    checks++; if (bus.readdata !== 8'h00) begin failures++; $display("FAIL rstwait_data got %h want 00", bus.readdata); end
    checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL rstwait_mem_rd got %b want 0", mem_rd); end
    checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL rstwait_mem_addr got %h want 0000", mem_addr); end
    reset = 1'b0;
    step();
    do_read(d, w);
    checks++; if (d !== 8'h7E) begin failures++; $display("FAIL rstwait_read got %h want 7e", d); end
    checks++; if (w !== 3) begin failures++; $display("FAIL rstwait_waits got %0d want 3", w); end
  endtask

  task automatic test_prefetch();
    logic [7:0] d;
    int w;
    set_ptr(16'h0040);
    for (int i = 0; i < 4; i++) step();
    do_read(d, w);
    checks++; if (w !== 0) begin failures++; $display("FAIL pf_hit_waits got %0d want 0", w); end
    checks++; if (d !== 8'h5C) begin failures++; $display("FAIL pf_hit_data got %h want 5c", d); end
    checks++; if (rd_ptr !== 16'h0041) begin failures++; $display("FAIL pf_ptr0 got %h want 0041", rd_ptr); end
    do_read(d, w);
    checks++; if (w !== 3) begin failures++; $display("FAIL pf_miss_waits got %0d want 3", w); end
    checks++; if (d !== 8'hC5) begin failures++; $display("FAIL pf_miss_data got %h want c5", d); end
    checks++; if (rd_ptr !== 16'h0042) begin failures++; $display("FAIL pf_ptr1 got %h want 0042", rd_ptr); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
    mem[16'h0010] = 8'hA5;
    mem[16'hFFFF] = 8'h3C;
    mem[16'h0000] = 8'h7E;
    mem[16'h0020] = 8'h11;
    mem[16'h0100] = 8'h22;
    mem[16'h0200] = 8'h44;
    mem[16'h0300] = 8'h99;
    mem[16'h0040] = 8'h5C;
    mem[16'h0041] = 8'hC5;

    test_reset();
`ifdef NES_RD_PREFETCH_EN
    test_prefetch();
`else
    test_basic();
    test_back_to_back_wrap();
    test_no_grant();
    test_abort();
    test_reset_in_wait();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
